instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch stage that drives the instruction ROM address and registers the returned word into the IF/ID pipeline register. It holds the program counter (PC), which is a byte address. The PC advances by 4 per accepted fetch, stalls under decode back-pressure, and redirects on taken branches/jumps. It sits between the asynchronous-read instruction ROM (32-bit data, 10-bit word address) and the decode stage.

Parameters:
D_ANCHO, 32, instruction width; must match the ROM data width.
A_ANCHO, 10, ROM word-address width; the ROM holds 2^A_ANCHO words.
RESET_PC, 32'h0000_0000, PC value after reset; must be 4-byte aligned.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST_N  in  1  reset; asynchronous, active-low.
START  in  1  one-cycle pulse; leaves IDLE and begins fetching.
ADDR  out  A_ANCHO  ROM word address = PC[A_ANCHO+1:2], combinational from PC.
DOUT  in  D_ANCHO  ROM read data; valid in the same cycle as ADDR.
BR_TAKEN  in  1  redirect request from EX.
BR_TARGET  in  32  redirect byte address.
ID_READY  in  1  decode can accept the IF/ID contents.
INSTR_ID  out  D_ANCHO  registered instruction.
PC_ID  out  32  byte PC of INSTR_ID.
VALID_ID  out  1  INSTR_ID/PC_ID are valid.
FAULT  out  1  sticky; set on misaligned or out-of-range PC.
PC  out  32  current fetch PC.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - State=IDLE, PC=RESET_PC, INSTR_ID=0, PC_ID=0, VALID_ID=0, FAULT=0.
  - ADDR follows PC combinationally.
- FSM states: IDLE, RUN, HALT.
  - IDLE→RUN when START=1. No fetch occurs in the START cycle; the first capture happens in the first RUN cycle.
  - RUN→HALT on a fault. HALT exits only via reset.
- Fetch rule in RUN: an advance occurs when (VALID_ID=0 or ID_READY=1) and BR_TAKEN=0. On an advance, at the edge:
  - INSTR_ID<=DOUT, PC_ID<=PC, VALID_ID<=1, PC<=PC+4.
  - Latency: ADDR→VALID_ID is 1 cycle.
- Stall: when VALID_ID=1 and ID_READY=0, PC, INSTR_ID, PC_ID and VALID_ID all hold.
- Redirect: BR_TAKEN=1 in RUN has priority over stall and advance.
  - PC<=BR_TARGET, VALID_ID<=0 (flush), INSTR_ID/PC_ID hold.
  - The next fetch comes from BR_TARGET one cycle later.
  - BR_TAKEN in IDLE or HALT is ignored.
- Faults are checked in RUN, at the edge:
  - BR_TAKEN=1 with BR_TARGET[1:0]≠0 → HALT, FAULT<=1, VALID_ID<=0, PC<=BR_TARGET (for debug).
  - An advance where PC+4 ≥ 4·2^A_ANCHO → the word at PC is still captured (VALID_ID<=1), PC<=PC+4, state<=HALT, FAULT<=1.
- In HALT: no further captures or PC changes. VALID_ID clears when the final word is consumed (ID_READY=1). Other outputs hold.
- PC arithmetic is 32-bit modulo 2^32; range checking is done in A_ANCHO+2 bits plus an upper-bit-nonzero test.
- START while in RUN or HALT is ignored.
- Simultaneous START and RST_N=0: reset wins.
- Reset mid-stall or mid-redirect returns immediately to the reset values.

Optional Feature:
FETCH_PERF_EN
- Defined: adds output ports CNT_FETCH[31:0] and CNT_STALL[31:0], both reset to 0.
  - CNT_FETCH increments on every advance.
  - CNT_STALL increments on every RUN cycle where VALID_ID=1 and ID_READY=0.
  - Neither counter increments in IDLE or HALT. Both wrap at 2^32.
- Undefined: these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, START pulse, ID_READY=1, ROM word n = 32'h1000_0000+n → VALID_ID rises 1 cycle after START. PC_ID/INSTR_ID step 0/1000_0000, 4/1000_0001, 8/1000_0002; ADDR=0,1,2,...
2. ID_READY=0 for 3 cycles at PC_ID=8 → INSTR_ID=1000_0002 and PC=0xC hold for all 3 cycles; fetch resumes with PC_ID=0xC. CNT_STALL=3 if FETCH_PERF_EN.
3. BR_TAKEN=1, BR_TARGET=0x40, with ID_READY=0 → next cycle VALID_ID=0 and PC=0x40; the following cycle INSTR_ID=1000_0010 and PC_ID=0x40.
4. BR_TARGET=0x42 → FAULT=1, state HALT, VALID_ID=0; a later START and BR_TAKEN leave PC=0x42 and FAULT=1.
5. Redirect to 0xFFC (last word, A_ANCHO=10) → INSTR_ID=1000_03FF with VALID_ID=1, then FAULT=1 and PC=0x1000; VALID_ID clears once ID_READY=1.
6. Assert RST_N=0 asynchronously mid-cycle during a stall → all outputs return to reset values before the next clock edge; a new START resumes from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, branch redirect, IF/ID register outputs.
// Optional perf counters appear when FETCH_PERF_EN is defined.
interface instr_fetch_unit_if #(
  parameter int D_ANCHO = 32,
  parameter int A_ANCHO = 10
);
  logic               START;
  logic [A_ANCHO-1:0] ADDR;
  logic [D_ANCHO-1:0] DOUT;
  logic               BR_TAKEN;
  logic [31:0]        BR_TARGET;
  logic               ID_READY;
  logic [D_ANCHO-1:0] INSTR_ID;
  logic [31:0]        PC_ID;
  logic               VALID_ID;
  logic               FAULT;
  logic [31:0]        PC;
`ifdef FETCH_PERF_EN
  logic [31:0]        CNT_FETCH;
  logic [31:0]        CNT_STALL;
`endif

  modport master (
    input  START, DOUT, BR_TAKEN, BR_TARGET, ID_READY,
`ifdef FETCH_PERF_EN
    output CNT_FETCH, CNT_STALL,
`endif
    output ADDR, INSTR_ID, PC_ID, VALID_ID, FAULT, PC
  );

  modport slave (
    output START, DOUT, BR_TAKEN, BR_TARGET, ID_READY,
`ifdef FETCH_PERF_EN
    input  CNT_FETCH, CNT_STALL,
`endif
    input  ADDR, INSTR_ID, PC_ID, VALID_ID, FAULT, PC
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, ROM addressing, IF/ID register, redirect and fault halt.
// Define FETCH_PERF_EN to add the CNT_FETCH/CNT_STALL performance counters.
module instr_fetch_unit #(
  parameter int          D_ANCHO  = 32,
  parameter int          A_ANCHO  = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                 CLK,
  input logic                 RST_N,
  instr_fetch_unit_if.master  fetch
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_e;

  state_e             state_q;
  logic [31:0]        pc_q;
  logic [D_ANCHO-1:0] instr_q;
  logic [31:0]        pc_id_q;
  logic               valid_q;
  logic               fault_q;

  logic [32:0]        pc_d;
  logic               range_fault;
  logic               misaligned;
  logic               advance;
  logic               stalled;

  // PC+4 kept one bit wider so a wrap past 2^32 still counts as out of range.
  always_comb begin
    pc_d        = {1'b0, pc_q} + 33'd4;
    range_fault = |pc_d[32:A_ANCHO+2];
    misaligned  = |fetch.BR_TARGET[1:0];
    advance     = (state_q == RUN) && !fetch.BR_TAKEN && (!valid_q || fetch.ID_READY);
    stalled     = (state_q == RUN) && valid_q && !fetch.ID_READY;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pc_id_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fetch.START) state_q <= RUN;
        end
        RUN: begin
          if (fetch.BR_TAKEN) begin
            pc_q    <= fetch.BR_TARGET;
            valid_q <= 1'b0;
            if (misaligned) begin
              state_q <= HALT;
              fault_q <= 1'b1;
            end
          end else if (advance) begin
            instr_q <= fetch.DOUT;
            pc_id_q <= pc_q;
            valid_q <= 1'b1;
            pc_q    <= pc_d[31:0];
            // The last in-range word is still delivered before halting.
            if (range_fault) begin
              state_q <= HALT;
              fault_q <= 1'b1;
            end
          end
        end
        HALT: begin
          if (fetch.ID_READY) valid_q <= 1'b0;
        end
        default: state_q <= HALT;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] cnt_fetch_q;
  logic [31:0] cnt_stall_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_fetch_q <= '0;
      cnt_stall_q <= '0;
    end else begin
      if (advance) cnt_fetch_q <= cnt_fetch_q + 32'd1;
      if (stalled) cnt_stall_q <= cnt_stall_q + 32'd1;
    end
  end

  assign fetch.CNT_FETCH = cnt_fetch_q;
  assign fetch.CNT_STALL = cnt_stall_q;
`else
  logic unused_stall;
  assign unused_stall = stalled;
`endif

  assign fetch.ADDR     = pc_q[A_ANCHO+1:2];
  assign fetch.PC       = pc_q;
  assign fetch.INSTR_ID = instr_q;
  assign fetch.PC_ID    = pc_id_q;
  assign fetch.VALID_ID = valid_q;
  assign fetch.FAULT    = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed plan steps followed by random traffic
// compared against a behavioural model of the fetch rules.
module tb_instr_fetch_unit;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.D_ANCHO(DW), .A_ANCHO(AW)) bus ();

  instr_fetch_unit #(
    .D_ANCHO (DW),
    .A_ANCHO (AW),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .fetch(bus)
  );

  logic [31:0] rom [WORDS];
  assign bus.DOUT = rom[bus.ADDR];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_run, m_halt;
  logic [31:0] m_pc, m_instr, m_pcid, m_cf, m_cs;
  logic        m_valid, m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_halt = 0;
    m_pc = 32'h0; m_instr = 32'h0; m_pcid = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0;
    m_cf = 32'h0; m_cs = 32'h0;
  endtask

  task automatic model_edge();
    bit stall_cycle;
    stall_cycle = m_run && m_valid && !bus.ID_READY;
    if (m_run) begin
      if (bus.BR_TAKEN) begin
        m_pc = bus.BR_TARGET;
        m_valid = 1'b0;
        if (bus.BR_TARGET % 4 != 0) begin
          m_run = 0; m_halt = 1; m_fault = 1'b1;
        end
      end else if (!m_valid || bus.ID_READY) begin
        m_instr = rom[(m_pc / 4) % WORDS];
        m_pcid  = m_pc;
        m_valid = 1'b1;
        m_cf    = m_cf + 1;
        if (longint'(m_pc) + 4 >= 4 * WORDS) begin
          m_run = 0; m_halt = 1; m_fault = 1'b1;
        end
        m_pc = m_pc + 4;
      end
    end else if (m_halt) begin
      if (bus.ID_READY) m_valid = 1'b0;
    end else if (bus.START) begin
      m_run = 1;
    end
    if (stall_cycle) m_cs = m_cs + 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  32'(bus.ADDR), (m_pc / 4) % WORDS);
    chk({tag, ".pc"},    bus.PC, m_pc);
    chk({tag, ".instr"}, bus.INSTR_ID, m_instr);
    chk({tag, ".pcid"},  bus.PC_ID, m_pcid);
    chk({tag, ".valid"}, 32'(bus.VALID_ID), 32'(m_valid));
    chk({tag, ".fault"}, 32'(bus.FAULT), 32'(m_fault));
`ifdef FETCH_PERF_EN
    chk({tag, ".cfetch"}, bus.CNT_FETCH, m_cf);
    chk({tag, ".cstall"}, bus.CNT_STALL, m_cs);
`endif
  endtask

  task automatic set_in(input logic start, input logic br, input logic [31:0] tgt, input logic rdy);
    bus.START = start; bus.BR_TAKEN = br; bus.BR_TARGET = tgt; bus.ID_READY = rdy;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asserts reset asynchronously wherever the bench currently is in the cycle.
  task automatic do_reset();
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) rom[i] = 32'h1000_0000 + 32'(i);
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    do_reset();

    // Plan 1: start and sequential fetch
    set_in(1'b1, 1'b0, 32'h0, 1'b1);
    step("start");
    chk("t1_nocap", 32'(bus.VALID_ID), 32'd0);
    set_in(1'b0, 1'b0, 32'h0, 1'b1);
    step("f0");
    chk("t1_pcid0", bus.PC_ID, 32'h0);
    chk("t1_ins0", bus.INSTR_ID, 32'h1000_0000);
    step("f1");
    chk("t1_pcid1", bus.PC_ID, 32'h4);
    step("f2");
    chk("t1_ins2", bus.INSTR_ID, 32'h1000_0002);
    chk("t1_addr", 32'(bus.ADDR), 32'd3);

    // Plan 2: three-cycle back-pressure
    bus.ID_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("t2_ins", bus.INSTR_ID, 32'h1000_0002);
      chk("t2_pc", bus.PC, 32'hC);
    end
`ifdef FETCH_PERF_EN
    chk("t2_cstall", bus.CNT_STALL, 32'd3);
`endif
    bus.ID_READY = 1'b1;
    step("resume");
    chk("t2_pcid", bus.PC_ID, 32'hC);

    // Plan 3: redirect under back-pressure
    set_in(1'b0, 1'b1, 32'h40, 1'b0);
    step("br");
    chk("t3_flush", 32'(bus.VALID_ID), 32'd0);
    chk("t3_pc", bus.PC, 32'h40);
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    step("br_fetch");
    chk("t3_ins", bus.INSTR_ID, 32'h1000_0010);
    chk("t3_pcid", bus.PC_ID, 32'h40);

    // Plan 4: misaligned redirect halts
    set_in(1'b0, 1'b1, 32'h42, 1'b1);
    step("mis");
    chk("t4_fault", 32'(bus.FAULT), 32'd1);
    chk("t4_valid", 32'(bus.VALID_ID), 32'd0);
    chk("t4_pc", bus.PC, 32'h42);
    set_in(1'b1, 1'b0, 32'h0, 1'b1);
    step("halt_start");
    set_in(1'b0, 1'b1, 32'h80, 1'b1);
    step("halt_br");
    chk("t4_pc_hold", bus.PC, 32'h42);
    chk("t4_fault_hold", 32'(bus.FAULT), 32'd1);

    // Plan 5: last ROM word then range fault
    do_reset();
    set_in(1'b1, 1'b0, 32'h0, 1'b1);
    step("s5");
    set_in(1'b0, 1'b1, 32'hFFC, 1'b1);
    step("br_end");
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    step("last");
    chk("t5_ins", bus.INSTR_ID, 32'h1000_03FF);
    chk("t5_valid", 32'(bus.VALID_ID), 32'd1);
    chk("t5_fault", 32'(bus.FAULT), 32'd1);
    chk("t5_pc", bus.PC, 32'h1000);
    step("last_hold");
    chk("t5_valid_hold", 32'(bus.VALID_ID), 32'd1);
    bus.ID_READY = 1'b1;
    step("last_drain");
    chk("t5_valid_clr", 32'(bus.VALID_ID), 32'd0);

    // Plan 6: async reset in the middle of a stall
    do_reset();
    set_in(1'b1, 1'b0, 32'h0, 1'b1);
    step("s6");
    bus.START = 1'b0;
    step("s6a");
    step("s6b");
    bus.ID_READY = 1'b0;
    step("s6stall");
    #2;
    do_reset();
    chk("t6_pc", bus.PC, 32'h0);
    chk("t6_valid", 32'(bus.VALID_ID), 32'd0);
    set_in(1'b1, 1'b0, 32'h0, 1'b1);
    step("s6r");
    bus.START = 1'b0;
    step("s6r_f");
    chk("t6_pcid", bus.PC_ID, 32'h0);
    chk("t6_ins", bus.INSTR_ID, 32'h1000_0000);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      int unsigned pick;
      if (m_halt && ($urandom % 8 == 0)) do_reset();
      pick = $urandom % 40;
      if (pick == 0)      tgt = 32'(($urandom_range(0, 1023) << 2) | $urandom_range(1, 3));
      else if (pick == 1) tgt = 32'hFF8;
      else if (pick == 2) tgt = 32'h0000_2000;
      else                tgt = 32'($urandom_range(0, 1023) << 2);
      set_in(1'($urandom % 6 == 0), 1'($urandom % 10 == 0), tgt, 1'($urandom % 4 != 0));
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
